// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF timestep scheduler.
// Holds the FSM state enum, the default membrane width and the saturating adder.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } lif_fsm_e;

  localparam int LIF_WIDTH = 8;

  // Unsigned add of two w-bit operands, clamped to 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leak-and-add update for one neuron, shared across all virtual neurons.
// Produces the saturated next membrane value and the threshold-crossing flag.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int WIDTH = LIF_WIDTH
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] state_i,
  input  logic             spiked_i,
  input  logic [WIDTH-1:0] thr_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             spk_o
);

  logic [WIDTH-1:0] leak;

  // A neuron that spiked last step contributes no leak term this step.
  assign leak  = spiked_i ? '0 : (state_i >> 1);
  assign nxt_o = WIDTH'(sat_add(32'(cur_i), 32'(leak), WIDTH));
  assign spk_o = (thr_i != '0) && (nxt_o >= thr_i);

endmodule

// File: rtl/lif_step_scheduler.sv
// Time-multiplexed LIF timestep scheduler: visits neurons in order, emits spikes over valid/ready.
// Optional refractory counters are built when LIF_REFRACTORY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for step_start; inputs latched on acceptance
// UPDATE | one neuron updated per cycle at idx
// EMIT   | spike event presented until spike_ready
// DONE   | step_done pulse, back to IDLE
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter  int NUM_NEURONS  = 4,
  parameter  int WIDTH        = LIF_WIDTH,
  parameter  int REFRAC_STEPS = 2,
  localparam int IW           = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step_start,
  input  logic [NUM_NEURONS*WIDTH-1:0] currents_in,
  input  logic [WIDTH-1:0]             threshold,
  output logic                         busy,
  output logic                         step_done,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [IW-1:0]                spike_idx,
  input  logic [IW-1:0]                rd_idx,
  output logic [WIDTH-1:0]             rd_state
);

  lif_fsm_e                     fsm_q, fsm_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [IW-1:0]                spike_idx_q, spike_idx_d;
  logic [NUM_NEURONS*WIDTH-1:0] cur_q;
  logic [WIDTH-1:0]             thr_q;
  logic [WIDTH-1:0]             state_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       spiked_q;

  logic [WIDTH-1:0] upd_nxt, wr_state;
  logic             upd_spk, spk, in_refrac, last, start_ok;

  assign last     = (idx_q == IW'(NUM_NEURONS - 1));
  assign start_ok = (fsm_q == IDLE) && step_start;

  lif_update_unit #(.WIDTH(WIDTH)) u_update (
    .cur_i   (cur_q[idx_q*WIDTH +: WIDTH]),
    .state_i (state_q[idx_q]),
    .spiked_i(spiked_q[idx_q]),
    .thr_i   (thr_q),
    .nxt_o   (upd_nxt),
    .spk_o   (upd_spk)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0] ref_q [NUM_NEURONS];

  assign in_refrac = (ref_q[idx_q] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) ref_q[i] <= '0;
    end else if (fsm_q == UPDATE) begin
      if (in_refrac)    ref_q[idx_q] <= ref_q[idx_q] - 1'b1;
      else if (upd_spk) ref_q[idx_q] <= RW'(REFRAC_STEPS);
    end
  end
`else
  logic unused_refrac;
  assign unused_refrac = (REFRAC_STEPS != 0);
  assign in_refrac     = 1'b0;
`endif

  // Refractory neurons are held at zero and cannot spike.
  assign wr_state = in_refrac ? '0 : upd_nxt;
  assign spk      = upd_spk && !in_refrac;

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    spike_idx_d = spike_idx_q;
    unique case (fsm_q)
      IDLE: begin
        if (step_start) begin
          fsm_d = UPDATE;
          idx_d = '0;
        end
      end
      UPDATE: begin
        if (spk) begin
          spike_idx_d = idx_q;
          fsm_d       = EMIT;
        end else if (last) begin
          fsm_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      EMIT: begin
        if (spike_ready) begin
          if (last) begin
            fsm_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            fsm_d = UPDATE;
          end
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      spike_idx_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      spike_idx_q <= spike_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) state_q[i] <= '0;
      spiked_q <= '0;
      cur_q    <= '0;
      thr_q    <= '0;
    end else begin
      if (start_ok) begin
        cur_q <= currents_in;
        thr_q <= threshold;
      end
      if (fsm_q == UPDATE) begin
        state_q[idx_q]  <= wr_state;
        spiked_q[idx_q] <= spk;
      end
    end
  end

  assign busy        = (fsm_q != IDLE);
  assign step_done   = (fsm_q == DONE);
  assign spike_valid = (fsm_q == EMIT);
  assign spike_idx   = spike_idx_q;
  assign rd_state    = state_q[rd_idx];

endmodule

// File: doc/lif_step_scheduler.md
Name: lif_step_scheduler

Overview:
- Time-multiplexes one leaky-integrate update datapath across NUM_NEURONS virtual neurons.
- On each timestep request it visits the neurons in index order, one per cycle. For each neuron it applies the leak-and-add update, compares the result against a threshold, and emits a spike event.
- Spike events leave over a valid/ready handshake.
- Sits between the input-current front end and the spike router.

Parameters:
- NUM_NEURONS, 4: number of virtual neurons (power of 2, at least 2).
- WIDTH, 8: membrane state and current width.
- REFRAC_STEPS, 2: refractory timesteps after a spike. Used only with LIF_REFRACTORY_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- step_start  in  1  single-cycle request to run one timestep.
- currents_in  in  NUM_NEURONS*WIDTH  per-neuron input current; neuron i occupies bits [i*WIDTH +: WIDTH].
- threshold  in  WIDTH  spike threshold; 0 disables spiking.
- busy  out  1  high from the cycle after an accepted step_start through the DONE cycle.
- step_done  out  1  one-cycle pulse when the timestep completes.
- spike_valid  out  1  a spike event is presented.
- spike_ready  in  1  downstream accepts the spike event.
- spike_idx  out  log2(NUM_NEURONS)  index of the spiking neuron.
- rd_idx  in  log2(NUM_NEURONS)  debug read select.
- rd_state  out  WIDTH  combinational read of state[rd_idx].

Behaviour:
- Reset: all of the following are cleared, and the FSM goes to IDLE:
  - state[], spiked[] flags, refractory counters
  - busy, step_done, spike_valid, spike_idx
- FSM states and transitions:
  - IDLE: on step_start, latch currents_in and threshold, set idx=0, go to UPDATE. step_start is ignored in every other state.
  - UPDATE: one cycle per neuron. Compute nxt for neuron idx. Write state[idx]=nxt and spiked[idx]=spk.
    - If spk: load spike_idx=idx, assert spike_valid, go to EMIT.
    - Else if idx==NUM_NEURONS-1: go to DONE.
    - Else: idx++.
  - EMIT: hold spike_valid and spike_idx stable until spike_ready is high.
    - On handshake, deassert spike_valid.
    - Then go to DONE if idx was last, otherwise idx++ and return to UPDATE.
  - DONE: step_done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Update arithmetic:
  - nxt = sat(cur[idx] + (spiked[idx] ? 0 : state[idx]>>1)).
  - The sum is computed WIDTH+1 bits wide and saturates to 2^WIDTH-1.
  - spk = (threshold != 0) && (nxt >= threshold).
  - The stored state is nxt. A spike suppresses the leak term on the following step; it does not zero the state.
- Latency:
  - With no spikes, step_done is asserted NUM_NEURONS+1 cycles after the step_start cycle.
  - Each spike adds at least 1 cycle, plus 1 cycle per cycle that spike_ready is low.
- Boundaries:
  - Latched currents and threshold are stable for the whole step; input changes mid-step have no effect.
  - A spike on the last neuron goes EMIT then DONE.
  - spike_ready high while spike_valid is low is ignored.
  - step_start asserted in the DONE cycle is ignored.
  - reset asserted mid-step aborts immediately. No step_done is produced and a pending spike is dropped.
  - rd_state reflects writes from the cycle after UPDATE.

Optional Feature:
- Macro LIF_REFRACTORY_EN.
- Defined:
  - Per-neuron counter ref[i], width covering REFRAC_STEPS.
  - On spike, ref[i]=REFRAC_STEPS.
  - While ref[i]!=0 during that neuron's UPDATE: state[i] is written 0, spk=0, spiked[i] is cleared, ref[i] decrements.
  - Cycle timing is unchanged.
- Undefined: no counters exist and REFRAC_STEPS is unused.

Decomposition:
- Package lif_pkg holds:
  - the FSM state enum (IDLE, UPDATE, EMIT, DONE)
  - a WIDTH default constant
  - a sat_add helper function
- One sub-module, lif_update_unit: combinational nxt/spk from cur, state, spiked, threshold, shared by all neurons. The FSM, state memory and handshake live in lif_step_scheduler.

Test Plan (NUM_NEURONS=4, WIDTH=8):
1. Integration, no spikes: reset, threshold=100, currents 10/20/30/40, step_start.
   - States become 10/20/30/40.
   - No spike_valid.
   - step_done is asserted 5 cycles after the step_start cycle.
   - A second step gives 15/30/45/60.
2. Spike with backpressure: threshold=50, current[2]=60, others 0, spike_ready held low 3 cycles.
   - spike_valid is held with spike_idx=2 stable for 4 cycles.
   - Handshake happens on the cycle ready is high.
   - step_done is asserted 5+1+3 cycles after the step_start cycle.
3. Spike suppresses leak: following the scenario 2 spike (state[2]=60), threshold=50, current[2]=10.
   - state[2]=10 (no leak term).
   - Next step with current 10 gives state[2]=15.
4. Saturation: state[0]=200, current[0]=200, threshold=0.
   - state[0]=255.
   - No spike, because threshold 0 disables spiking.
5. Reset and ignored start:
   - Assert reset 1 cycle during the UPDATE of idx=1: all states 0, busy=0, no step_done.
   - step_start while busy is ignored: exactly one step_done per accepted start.
6. Refractory, LIF_REFRACTORY_EN with REFRAC_STEPS=2: threshold=50, current[1]=60 every step.
   - Spike on step 1.
   - state[1]=0 and no spike on steps 2 and 3.
   - Spike again on step 4.
